// File: rtl/ga_logic_array.sv
// ga_logic_array: DEPTH x WIDTH grid of 2-input LUT cells, one row per clock.
// The host loads the genome serially (LSB-first in load order). Input vectors
// then stream through the array at one vector per clock.
// Optional build macro GA_LOGIC_ARRAY_READBACK_EN: while a new genome loads,
// CFG_DOUT streams the old genome back in load order.
module ga_logic_array #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic             FPGA_CLK_50,
  input  logic             RST,
  input  logic             CFG_START,
  input  logic             CFG_VALID,
  input  logic             CFG_BIT,
  output logic             CFG_READY,
  output logic             CFG_DONE,
  output logic             CFG_DOUT,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             IN_READY,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] OUT_DATA
);

  localparam int GENOME_BITS = WIDTH * DEPTH * 4;
  localparam int CNT_W       = $clog2(GENOME_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOADED} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [GENOME_BITS-1:0] genome;
  logic                   shift;

  // Pipeline: vld_pipe[0] is the accept strobe, vld_pipe[r+1] qualifies rows[r].
  logic [DEPTH:1]                  vld_q;
  logic [DEPTH:0]                  vld_pipe;
  logic [DEPTH-1:0][WIDTH-1:0]     rows;
  logic [DEPTH-1:0][WIDTH-1:0]     cells;
  logic [DEPTH:0][WIDTH-1:0]       stage_in;

  // A bit is taken only while loading; a simultaneous restart drops it.
  assign shift = (state == S_LOAD) && CFG_VALID && !CFG_START;

  // Config FSM state and bit counter.
  always_ff @(posedge FPGA_CLK_50) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and status outputs; CFG_START restarts from any state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    CFG_READY = 1'b0;
    CFG_DONE  = 1'b0;
    case (state)
      S_LOAD:   CFG_READY = 1'b1;
      S_LOADED: CFG_DONE  = 1'b1;
      default:  ;
    endcase
    if (CFG_START) begin
      state_nxt = S_LOAD;
      cnt_nxt   = '0;
    end else if (shift) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == CNT_W'(GENOME_BITS - 1)) state_nxt = S_LOADED;
    end
  end

  assign IN_READY = CFG_DONE;

  // Genome shift register: new bits enter at the MSB so the first bit of a
  // full load ends up in genome[0]. Frozen outside LOAD.
  always_ff @(posedge FPGA_CLK_50) begin
    if (RST)        genome <= '0;
    else if (shift) genome <= {CFG_BIT, genome[GENOME_BITS-1:1]};
  end

`ifdef GA_LOGIC_ARRAY_READBACK_EN
  logic dout;

  // Capture the bit falling off the bottom of the genome on every shift.
  always_ff @(posedge FPGA_CLK_50) begin
    if (RST)        dout <= 1'b0;
    else if (shift) dout <= genome[0];
  end

  assign CFG_DOUT = dout;
`else
  assign CFG_DOUT = 1'b0;
`endif

  // Row r reads stage_in[r]; stage_in[0] is the input port, the top entry is
  // the last row register, i.e. the array output.
  assign stage_in = {rows, IN_DATA};
  assign vld_pipe = {vld_q, IN_VALID & IN_READY};

  // LUT evaluation: cell (r,c) sees a = prev[c], b = prev[c+1] (wrapping),
  // and its 4-bit truth table is indexed by {a,b}.
  always_comb begin
    cells = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        cells[r][c] = genome[(r * WIDTH + c) * 4 +
                             {stage_in[r][c], stage_in[r][(c + 1) % WIDTH]}];
      end
    end
  end

  // Row registers advance only with valid data; a restart kills everything in
  // flight and leaves the rows (and so OUT_DATA) untouched.
  always_ff @(posedge FPGA_CLK_50) begin
    if (RST) begin
      vld_q <= '0;
      rows  <= '0;
    end else if (CFG_START) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_pipe[DEPTH-1:0];
      for (int r = 0; r < DEPTH; r++) begin
        if (vld_pipe[r]) rows[r] <= cells[r];
      end
    end
  end

  assign OUT_VALID = vld_pipe[DEPTH];
  assign OUT_DATA  = stage_in[DEPTH];

endmodule

// File: tb/tb_ga_logic_array.sv
// Scoreboard bench for ga_logic_array (WIDTH=4, DEPTH=3, 48 genome bits).
// Stimulus pushes {expected data, expected cycle}; a negedge monitor pops on
// every OUT_VALID and compares both.
module tb_ga_logic_array;
  localparam int W  = 4;
  localparam int D  = 3;
  localparam int GB = W * D * 4;

  logic         FPGA_CLK_50 = 1'b0;
  logic         RST = 1'b1;
  logic         CFG_START = 1'b0, CFG_VALID = 1'b0, CFG_BIT = 1'b0;
  logic         CFG_READY, CFG_DONE, CFG_DOUT;
  logic         IN_VALID = 1'b0;
  logic [W-1:0] IN_DATA = '0;
  logic         IN_READY, OUT_VALID;
  logic [W-1:0] OUT_DATA;

  ga_logic_array #(.WIDTH(W), .DEPTH(D)) dut (
    .FPGA_CLK_50(FPGA_CLK_50), .RST(RST),
    .CFG_START(CFG_START), .CFG_VALID(CFG_VALID), .CFG_BIT(CFG_BIT),
    .CFG_READY(CFG_READY), .CFG_DONE(CFG_DONE), .CFG_DOUT(CFG_DOUT),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA)
  );

  always #10 FPGA_CLK_50 = ~FPGA_CLK_50;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [GB-1:0] prev_g = '0;

  always @(posedge FPGA_CLK_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge FPGA_CLK_50);
    #1;
  endtask

  // Monitor: every OUT_VALID must match the oldest expected entry, on time.
  always @(negedge FPGA_CLK_50) begin
    if (OUT_VALID === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", OUT_VALID, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", OUT_DATA, e.data);
        check("out_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one vector for one cycle; push the result only if it must emerge.
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] exp, input bit acc);
    exp_t e;
    IN_VALID = 1'b1;
    IN_DATA  = d;
    if (acc) begin
      e.data = exp;
      e.cyc  = cyc + D;
      sb.push_back(e);
    end
    tick;
    IN_VALID = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick;
    check("drain_empty", sb.size(), 0);
  endtask

  // Load genome g: bit g[i] is sent i-th. Optional gaps in CFG_VALID and a
  // bit offered together with CFG_START (which must be dropped).
  task automatic load_genome(input logic [GB-1:0] g, input bit gaps, input bit drop_first);
    logic [GB-1:0] rb;
    rb = '0;
    CFG_START = 1'b1;
    CFG_VALID = drop_first;
    CFG_BIT   = 1'b1;
    tick;
    CFG_START = 1'b0;
    CFG_VALID = 1'b0;
    check("cfg_ready_load", CFG_READY, 1'b1);
    check("in_ready_load", IN_READY, 1'b0);
    for (int i = 0; i < GB; i++) begin
      if (gaps && (i % 7) == 3) begin
        CFG_VALID = 1'b0;
        CFG_BIT   = ~g[i];
        tick;
      end
      CFG_VALID = 1'b1;
      CFG_BIT   = g[i];
      tick;
      rb[i] = CFG_DOUT;
      if (i == GB - 2) begin
        check("cfg_done_early", CFG_DONE, 1'b0);
        check("cfg_ready_early", CFG_READY, 1'b1);
      end
    end
    CFG_VALID = 1'b0;
    check("cfg_done_rise", CFG_DONE, 1'b1);
    check("cfg_ready_fall", CFG_READY, 1'b0);
    check("in_ready_done", IN_READY, 1'b1);
`ifdef GA_LOGIC_ARRAY_READBACK_EN
    check("readback", rb, prev_g);
`else
    check("dout_zero", rb, '0);
`endif
    prev_g = g;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset, then idle with IN_VALID and CFG_VALID ignored
    repeat (2) tick;
    check("rst_out_valid", OUT_VALID, 1'b0);
    RST = 1'b0;
    tick;
    check("rst_cfg_ready", CFG_READY, 1'b0);
    check("rst_cfg_done", CFG_DONE, 1'b0);
    check("rst_cfg_dout", CFG_DOUT, 1'b0);
    check("rst_out_valid2", OUT_VALID, 1'b0);
    check("rst_out_data", OUT_DATA, 4'h0);
    check("rst_in_ready", IN_READY, 1'b0);
    CFG_VALID = 1'b1;
    CFG_BIT   = 1'b1;
    for (int i = 0; i < 4; i++) send(4'hF, 4'h0, 1'b0);
    CFG_VALID = 1'b0;
    repeat (4) tick;
    check("idle_out_valid", OUT_VALID, 1'b0);

    // 2: pass-a everywhere; CFG_VALID while loaded must not disturb genome
    load_genome(48'hCCCC_CCCC_CCCC, 1'b0, 1'b0);
    CFG_VALID = 1'b1;
    CFG_BIT   = 1'b0;
    repeat (3) tick;
    CFG_VALID = 1'b0;
    check("done_static", CFG_DONE, 1'b1);
    send(4'b1011, 4'b1011, 1'b1);
    drain;

    // 3: AND everywhere, with row register contents
    load_genome(48'h8888_8888_8888, 1'b1, 1'b0);
    send(4'b1111, 4'b1111, 1'b1);
    send(4'b0111, 4'b0000, 1'b1);
    drain;
    check("row0", dut.rows[0], 4'b0011);
    check("row1", dut.rows[1], 4'b0001);

    // 4: pass-b rotates each row; 5 back-to-back vectors
    load_genome(48'hAAAA_AAAA_AAAA, 1'b0, 1'b0);
    send(4'b0001, 4'b0010, 1'b1);
    send(4'b0011, 4'b0110, 1'b1);
    send(4'b1000, 4'b0001, 1'b1);
    send(4'b1010, 4'b0101, 1'b1);
    send(4'b0110, 4'b1100, 1'b1);
    drain;
    repeat (3) tick;
    check("hold_out_valid", OUT_VALID, 1'b0);
    check("hold_out_data", OUT_DATA, 4'b1100);

    // Per-cell genome: row0 = {0, 1, a, ~a}, row1 pass-a, row2 pass-b
    load_genome(48'hAAAA_CCCC_0FC3, 1'b1, 1'b0);
    send(4'b0101, 4'b0010, 1'b1);
    send(4'b1010, 4'b1011, 1'b1);
    drain;

    // 5: restart with 2 vectors in flight; bit offered with CFG_START dropped
    send(4'b1111, 4'b0000, 1'b0);
    send(4'b0001, 4'b0000, 1'b0);
    load_genome(48'hCCCC_CCCC_CCCC, 1'b1, 1'b1);
    check("flush_hold_data", OUT_DATA, 4'b1011);
    send(4'b0110, 4'b0110, 1'b1);
    drain;

    repeat (4) tick;
    check("final_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
